// File: rtl/id_stage_reg_if.sv
// Fetch-to-decode bus for id_stage_reg: input handshake, head entry and decoded fields.
// Optional extended outputs exist only when ID_INLINE_EXT_EN is defined.
interface id_stage_reg_if #(
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [PC_W-1:0] out_pc;
    logic [5:0]      out_op;
    logic [4:0]      out_rs;
    logic [4:0]      out_rt;
    logic [4:0]      out_rd;
    logic [4:0]      out_shamt;
    logic [5:0]      out_funct;
    logic [15:0]     out_imm16;
`ifdef ID_INLINE_EXT_EN
    logic [31:0]     out_imm32;
    logic [31:0]     out_shamt32;
`endif

    // The decode stage itself.
    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc,
               out_op, out_rs, out_rt, out_rd, out_shamt, out_funct, out_imm16
`ifdef ID_INLINE_EXT_EN
        , output out_imm32, out_shamt32
`endif
    );

    // Fetch on the input side plus the consumer of the decoded entry.
    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc,
               out_op, out_rs, out_rt, out_rd, out_shamt, out_funct, out_imm16
`ifdef ID_INLINE_EXT_EN
        , input out_imm32, out_shamt32
`endif
    );
endinterface

// File: rtl/id_stage_reg.sv
// MIPS decode input stage: two-entry skid buffer of {instr, pc} with field decode of the head.
// Define ID_INLINE_EXT_EN to add out_imm32 / out_shamt32 extended outputs.
module id_stage_reg #(
    parameter int PC_W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    id_stage_reg_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    typedef struct packed {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
    } entry_t;

    state_t state;
    entry_t head;
    entry_t skid;
    entry_t in_entry;
    logic   in_ready_q;
    logic   out_valid_q;
    logic   in_fire;
    logic   out_fire;

    assign in_entry = '{instr: bus.in_instr, pc: bus.in_pc};
    assign in_fire  = bus.in_valid & in_ready_q;
    assign out_fire = out_valid_q & bus.out_ready;

    // in_ready is its own register so back-pressure never reaches fetch combinationally.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register updating from pre-edge values.
        if (rst) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            // NOTE: head/skid are cleared on reset so the field outputs read 0 out of reset;
            // flush only clears the state, leaving data as don't-care.
            head        <= '0;
            skid        <= '0;
        end else if (flush) begin
            state       <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        head        <= in_entry;
                        state       <= ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        head <= in_entry;
                    end else if (in_fire) begin
                        skid       <= in_entry;
                        state      <= TWO;
                        in_ready_q <= 1'b0;
                    end else if (out_fire) begin
                        state       <= EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        head       <= skid;
                        state      <= ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = head.instr;
    assign bus.out_pc    = head.pc;
    assign bus.out_op    = head.instr[31:26];
    assign bus.out_rs    = head.instr[25:21];
    assign bus.out_rt    = head.instr[20:16];
    assign bus.out_rd    = head.instr[15:11];
    assign bus.out_shamt = head.instr[10:6];
    assign bus.out_funct = head.instr[5:0];
    assign bus.out_imm16 = head.instr[15:0];

`ifdef ID_INLINE_EXT_EN
    logic zero_ext;

    // andi/ori/xori/lui are opcodes 0x0C-0x0F, i.e. the top four opcode bits are 0011.
    assign zero_ext        = (head.instr[31:28] == 4'b0011);
    assign bus.out_imm32   = zero_ext ? {16'b0, head.instr[15:0]}
                                      : {{16{head.instr[15]}}, head.instr[15:0]};
    assign bus.out_shamt32 = {27'b0, head.instr[10:6]};
`endif
endmodule

// File: tb/tb_id_stage_reg.sv
// Self-checking bench for id_stage_reg: directed vector table, then random traffic vs a queue model.
module tb_id_stage_reg;
    localparam int PC_W = 32;

    logic clk;
    logic rst;
    logic flush;

    id_stage_reg_if #(.PC_W(PC_W)) bus ();

    id_stage_reg #(.PC_W(PC_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic f, input logic iv,
                         input logic [31:0] instr, input logic [31:0] pc, input logic ordy);
        rst           = r;
        flush         = f;
        bus.in_valid  = iv;
        bus.in_instr  = instr;
        bus.in_pc     = pc;
        bus.out_ready = ordy;
    endtask

    // Fields derived from an instruction word with plain arithmetic.
    task automatic check_fields(input string tag, input logic [31:0] w);
        int unsigned op, imm, imm32;
        op  = w >> 26;
        imm = w % 65536;
        if (op >= 12 && op <= 15) imm32 = imm;
        else if (imm >= 32768)    imm32 = imm + 32'hFFFF_0000;
        else                      imm32 = imm;
        check({tag, "_op"},    bus.out_op,    op);
        check({tag, "_rs"},    bus.out_rs,    (w >> 21) % 32);
        check({tag, "_rt"},    bus.out_rt,    (w >> 16) % 32);
        check({tag, "_rd"},    bus.out_rd,    (w >> 11) % 32);
        check({tag, "_shamt"}, bus.out_shamt, (w >> 6) % 32);
        check({tag, "_funct"}, bus.out_funct, w % 64);
        check({tag, "_imm16"}, bus.out_imm16, imm);
`ifdef ID_INLINE_EXT_EN
        check({tag, "_imm32"},   bus.out_imm32,   imm32);
        check({tag, "_shamt32"}, bus.out_shamt32, (w >> 6) % 32);
`endif
    endtask

    typedef struct {
        logic        rst;
        logic        flush;
        logic        iv;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        ordy;
        logic        ev;
        logic        er;
        logic        chk;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [31:0] imm32;
        logic [31:0] sh32;
    } fld_t;

    localparam logic [31:0] SLL  = 32'h0008_4140;
    localparam logic [31:0] ADDI = 32'h2008_FFDB;
    localparam logic [31:0] ANDI = 32'h3108_FFDB;
    localparam logic [31:0] IA = 32'h1111_1111, IB = 32'h2222_2222, IC = 32'h3333_3333;
    localparam logic [31:0] ID = 32'h4444_4444, IE = 32'h5555_5555, IF = 32'h6666_6666;
    localparam logic [31:0] IG = 32'h7777_7777, IH = 32'h8888_8888, IJ = 32'h9999_9999;

    vec_t tv[23];
    fld_t fld[4];

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t q[$];
    bit   head_zero;

    initial begin
        fld[0] = '{32'h0,  6'h00, 5'd0, 5'd0, 5'd0,  5'd0,  6'h00, 16'h0000, 32'h0000_0000, 32'd0};
        fld[1] = '{SLL,    6'h00, 5'd0, 5'd8, 5'd8,  5'd5,  6'h00, 16'h4140, 32'h0000_4140, 32'd5};
        fld[2] = '{ADDI,   6'h08, 5'd0, 5'd8, 5'd31, 5'd31, 6'h1B, 16'hFFDB, 32'hFFFF_FFDB, 32'd31};
        fld[3] = '{ANDI,   6'h0C, 5'd8, 5'd8, 5'd31, 5'd31, 6'h1B, 16'hFFDB, 32'h0000_FFDB, 32'd31};

        //          rst  fl   iv   instr pc        ordy ev   er   chk  e_instr e_pc
        tv[0]  = '{1'b0,1'b0,1'b0,32'h0,32'h0,    1'b1,1'b0,1'b1,1'b1,32'h0,32'h0};
        tv[1]  = '{1'b0,1'b0,1'b0,32'h0,32'h0,    1'b1,1'b0,1'b1,1'b1,32'h0,32'h0};
        tv[2]  = '{1'b0,1'b0,1'b0,32'h0,32'h0,    1'b1,1'b0,1'b1,1'b1,32'h0,32'h0};
        tv[3]  = '{1'b0,1'b0,1'b1,SLL,  32'h100,  1'b1,1'b1,1'b1,1'b1,SLL,  32'h100};
        tv[4]  = '{1'b0,1'b0,1'b1,ADDI, 32'h104,  1'b1,1'b1,1'b1,1'b1,ADDI, 32'h104};
        tv[5]  = '{1'b0,1'b0,1'b1,ANDI, 32'h108,  1'b1,1'b1,1'b1,1'b1,ANDI, 32'h108};
        tv[6]  = '{1'b0,1'b0,1'b0,32'h0,32'h0,    1'b1,1'b0,1'b1,1'b0,32'h0,32'h0};
        tv[7]  = '{1'b0,1'b0,1'b1,IA,   32'h200,  1'b0,1'b1,1'b1,1'b1,IA,   32'h200};
        tv[8]  = '{1'b0,1'b0,1'b1,IB,   32'h204,  1'b0,1'b1,1'b0,1'b1,IA,   32'h200};
        tv[9]  = '{1'b0,1'b0,1'b1,IC,   32'h208,  1'b0,1'b1,1'b0,1'b1,IA,   32'h200};
        tv[10] = '{1'b0,1'b0,1'b1,IC,   32'h208,  1'b0,1'b1,1'b0,1'b1,IA,   32'h200};
        tv[11] = '{1'b0,1'b0,1'b1,IC,   32'h208,  1'b1,1'b1,1'b1,1'b1,IB,   32'h204};
        tv[12] = '{1'b0,1'b0,1'b1,IC,   32'h208,  1'b0,1'b1,1'b0,1'b1,IB,   32'h204};
        tv[13] = '{1'b0,1'b0,1'b0,32'h0,32'h0,    1'b1,1'b1,1'b1,1'b1,IC,   32'h208};
        tv[14] = '{1'b0,1'b0,1'b0,32'h0,32'h0,    1'b1,1'b0,1'b1,1'b0,32'h0,32'h0};
        tv[15] = '{1'b0,1'b0,1'b1,ID,   32'h300,  1'b0,1'b1,1'b1,1'b1,ID,   32'h300};
        tv[16] = '{1'b0,1'b1,1'b1,IE,   32'h304,  1'b0,1'b0,1'b1,1'b0,32'h0,32'h0};
        tv[17] = '{1'b0,1'b0,1'b0,32'h0,32'h0,    1'b1,1'b0,1'b1,1'b0,32'h0,32'h0};
        tv[18] = '{1'b0,1'b0,1'b1,IF,   32'h400,  1'b0,1'b1,1'b1,1'b1,IF,   32'h400};
        tv[19] = '{1'b0,1'b0,1'b1,IG,   32'h404,  1'b0,1'b1,1'b0,1'b1,IF,   32'h400};
        tv[20] = '{1'b1,1'b0,1'b1,IH,   32'h408,  1'b0,1'b0,1'b1,1'b1,32'h0,32'h0};
        tv[21] = '{1'b0,1'b0,1'b1,IJ,   32'h500,  1'b1,1'b1,1'b1,1'b1,IJ,   32'h500};
        tv[22] = '{1'b0,1'b0,1'b0,32'h0,32'h0,    1'b1,1'b0,1'b1,1'b0,32'h0,32'h0};

        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        cycle();
        cycle();

        // Directed sequence: each row is one clock, outputs checked just after the edge.
        for (int i = 0; i < 23; i++) begin
            drive(tv[i].rst, tv[i].flush, tv[i].iv, tv[i].instr, tv[i].pc, tv[i].ordy);
            cycle();
            check($sformatf("vec%0d_out_valid", i), bus.out_valid, tv[i].ev);
            check($sformatf("vec%0d_in_ready", i),  bus.in_ready,  tv[i].er);
            if (tv[i].chk) begin
                check($sformatf("vec%0d_out_instr", i), bus.out_instr, tv[i].e_instr);
                check($sformatf("vec%0d_out_pc", i),    bus.out_pc,    tv[i].e_pc);
                for (int f = 0; f < 4; f++) begin
                    if (fld[f].instr == tv[i].e_instr) begin
                        check($sformatf("vec%0d_op", i),    bus.out_op,    fld[f].op);
                        check($sformatf("vec%0d_rs", i),    bus.out_rs,    fld[f].rs);
                        check($sformatf("vec%0d_rt", i),    bus.out_rt,    fld[f].rt);
                        check($sformatf("vec%0d_rd", i),    bus.out_rd,    fld[f].rd);
                        check($sformatf("vec%0d_shamt", i), bus.out_shamt, fld[f].sh);
                        check($sformatf("vec%0d_funct", i), bus.out_funct, fld[f].fn);
                        check($sformatf("vec%0d_imm16", i), bus.out_imm16, fld[f].imm);
`ifdef ID_INLINE_EXT_EN
                        check($sformatf("vec%0d_imm32", i),   bus.out_imm32,   fld[f].imm32);
                        check($sformatf("vec%0d_shamt32", i), bus.out_shamt32, fld[f].sh32);
`endif
                    end
                end
            end
        end

        // Random traffic against a bounded FIFO model of depth two.
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        cycle();
        q.delete();
        head_zero = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            logic        r, f, iv, ordy;
            logic [31:0] w, pc;
            bit          acc_in, acc_out;
            r    = ($urandom_range(0, 79) == 0);
            f    = ($urandom_range(0, 24) == 0);
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            w    = $urandom;
            pc   = $urandom;
            drive(r, f, iv, w, pc, ordy);

            acc_in  = iv && (q.size() < 2);
            acc_out = ordy && (q.size() > 0);
            if (r) begin
                q.delete();
                head_zero = 1'b1;
            end else begin
                if (acc_out) void'(q.pop_front());
                if (f) q.delete();
                else if (acc_in) begin
                    q.push_back('{w, pc});
                    head_zero = 1'b0;
                end
            end

            cycle();
            check("rand_out_valid", bus.out_valid, q.size() > 0);
            check("rand_in_ready",  bus.in_ready,  q.size() < 2);
            if (q.size() > 0) begin
                check("rand_out_instr", bus.out_instr, q[0].instr);
                check("rand_out_pc",    bus.out_pc,    q[0].pc);
                check_fields("rand", q[0].instr);
            end else if (head_zero) begin
                check("rand_rst_instr", bus.out_instr, 32'h0);
                check("rand_rst_pc",    bus.out_pc,    32'h0);
                check_fields("rand_rst", 32'h0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
